// File: rtl/nn_train_sequencer_if.sv
// Control/status bundle between the frame sequencer and its surroundings.
// slave = the sequencer, master = feature source / key / datapath observer side.
interface nn_train_sequencer_if #(
  parameter int EPOCH_W = 16
);
  logic               iFrameSync;
  logic               iXAvail;
  logic               iXFull;
  logic               iTrain;
  logic               oNewFrame;
  logic               oComputeH;
  logic               oClassify;
  logic               oUpRule;
  logic               oBusy;
  logic               oTrainPend;
  logic               oErr;
  logic [EPOCH_W-1:0] oEpoch;
  logic [2:0]         oState;

  modport master (
    output iFrameSync, iXAvail, iXFull, iTrain,
    input  oNewFrame, oComputeH, oClassify, oUpRule, oBusy,
    input  oTrainPend, oErr, oEpoch, oState
  );

  modport slave (
    input  iFrameSync, iXAvail, iXFull, iTrain,
    output oNewFrame, oComputeH, oClassify, oUpRule, oBusy,
    output oTrainPend, oErr, oEpoch, oState
  );
endinterface

// File: rtl/nn_train_sequencer.sv
// Per-frame sequencer: clear Hw, accumulate features, classify, optional weight-update pass.
// Define NN_SEQ_WDOG_EN to add a watchdog that bails out of ACCUM/UPDATE after WDOG_CYCLES.
module nn_train_sequencer #(
  parameter int N_INPUTS        = 1024,
  parameter int CLASSIFY_CYCLES = 2,
  parameter int EPOCH_W         = 16,
  parameter int WDOG_CYCLES     = 1 << 20
) (
  input  logic                 iCLK,
  input  logic                 iRST_N,
  nn_train_sequencer_if.slave  bus
);

  localparam int CNT_W = $clog2(N_INPUTS + 1);
  localparam int CLS_W = $clog2(CLASSIFY_CYCLES + 1);
  localparam logic [CNT_W-1:0] N_CNT    = CNT_W'(N_INPUTS);
  localparam logic [CLS_W-1:0] CLS_LAST = CLS_W'(CLASSIFY_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CLEAR    = 3'd1,
    S_ACCUM    = 3'd2,
    S_CLASSIFY = 3'd3,
    S_WAIT_UPD = 3'd4,
    S_UPDATE   = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CLS_W-1:0]   cls_q, cls_d;
  logic               train_r_q, train_r_d;
  logic               train_pend_q, train_pend_d;
  logic               err_q, err_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic               new_frame_q, new_frame_d;
  logic               compute_h_q, compute_h_d;
  logic               classify_q, classify_d;
  logic               up_rule_q, up_rule_d;
  logic               busy_q, busy_d;

  logic [CNT_W-1:0]   strobe_cnt;
  logic               vec_done;
  logic               vec_short;
  logic               train_rise;
  logic               pend_window;

`ifdef NN_SEQ_WDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 1);
  logic [WD_W-1:0] wdog_q, wdog_d;
`endif

  // Feature count including this cycle's strobe; the vector ends on the Nth strobe or iXFull.
  always_comb begin
    strobe_cnt = count_q;
    if (bus.iXAvail && (count_q != N_CNT)) begin
      strobe_cnt = count_q + CNT_W'(1);
    end
    vec_done    = (strobe_cnt == N_CNT) || bus.iXFull;
    vec_short   = bus.iXFull && (strobe_cnt != N_CNT);
    train_rise  = bus.iTrain && !train_r_q;
    pend_window = (state_q == S_IDLE) || (state_q == S_CLEAR) ||
                  (state_q == S_ACCUM) || (state_q == S_CLASSIFY);
  end

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    cls_d        = cls_q;
    err_d        = err_q;
    epoch_d      = epoch_q;
    train_r_d    = bus.iTrain;
    train_pend_d = train_pend_q || (train_rise && pend_window);

    case (state_q)
      S_IDLE: begin
        if (bus.iFrameSync) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        count_d = '0;
        state_d = S_ACCUM;
      end
      S_ACCUM: begin
        count_d = strobe_cnt;
        // Completion beats a coincident frame sync; the sync is simply dropped.
        if (vec_done) begin
          state_d = S_CLASSIFY;
          cls_d   = '0;
          if (vec_short) err_d = 1'b1;
        end else if (bus.iFrameSync) begin
          err_d   = 1'b1;
          state_d = S_CLEAR;
        end
      end
      S_CLASSIFY: begin
        if (cls_q == CLS_LAST) begin
          state_d = train_pend_d ? S_WAIT_UPD : S_IDLE;
        end else begin
          cls_d = cls_q + CLS_W'(1);
        end
      end
      S_WAIT_UPD: begin
        // Hw sum from the classified frame is kept, so no clear pulse here.
        if (bus.iFrameSync) begin
          count_d = '0;
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        count_d = strobe_cnt;
        if (vec_done) begin
          state_d = S_DONE;
          if (vec_short) err_d = 1'b1;
        end else if (bus.iFrameSync) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        epoch_d      = epoch_q + EPOCH_W'(1);
        train_pend_d = 1'b0;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

`ifdef NN_SEQ_WDOG_EN
    if (((state_q == S_ACCUM) || (state_q == S_UPDATE)) && (wdog_q == WD_LAST)) begin
      state_d      = S_IDLE;
      err_d        = 1'b1;
      train_pend_d = 1'b0;
    end
    wdog_d = '0;
    if ((state_d == state_q) && ((state_q == S_ACCUM) || (state_q == S_UPDATE))) begin
      wdog_d = wdog_q + WD_W'(1);
    end
`endif

    // Outputs are registered from the next state so they align with oState.
    new_frame_d = (state_d == S_CLEAR);
    compute_h_d = (state_d == S_ACCUM);
    classify_d  = (state_d == S_CLASSIFY);
    up_rule_d   = (state_d == S_UPDATE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      cls_q        <= '0;
      train_r_q    <= 1'b0;
      train_pend_q <= 1'b0;
      err_q        <= 1'b0;
      epoch_q      <= '0;
      new_frame_q  <= 1'b0;
      compute_h_q  <= 1'b0;
      classify_q   <= 1'b0;
      up_rule_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      cls_q        <= cls_d;
      train_r_q    <= train_r_d;
      train_pend_q <= train_pend_d;
      err_q        <= err_d;
      epoch_q      <= epoch_d;
      new_frame_q  <= new_frame_d;
      compute_h_q  <= compute_h_d;
      classify_q   <= classify_d;
      up_rule_q    <= up_rule_d;
      busy_q       <= busy_d;
    end
  end

`ifdef NN_SEQ_WDOG_EN
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) wdog_q <= '0;
    else         wdog_q <= wdog_d;
  end
`endif

  assign bus.oNewFrame  = new_frame_q;
  assign bus.oComputeH  = compute_h_q;
  assign bus.oClassify  = classify_q;
  assign bus.oUpRule    = up_rule_q;
  assign bus.oBusy      = busy_q;
  assign bus.oTrainPend = train_pend_q;
  assign bus.oErr       = err_q;
  assign bus.oEpoch     = epoch_q;
  assign bus.oState     = state_q;

endmodule

// File: tb/tb_nn_train_sequencer.sv
// Directed bench for nn_train_sequencer with N_INPUTS=16, CLASSIFY_CYCLES=2, EPOCH_W=2.
// The watchdog step only runs when NN_SEQ_WDOG_EN is defined (WDOG_CYCLES=100).
module tb_nn_train_sequencer;

  localparam int EPOCH_W = 2;

  logic iCLK;
  logic iRST_N;
  int   n_cmp;
  int   n_err;

  nn_train_sequencer_if #(.EPOCH_W(EPOCH_W)) bus ();

  nn_train_sequencer #(
    .N_INPUTS        (16),
    .CLASSIFY_CYCLES (2),
    .EPOCH_W         (EPOCH_W),
    .WDOG_CYCLES     (100)
  ) dut (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .bus    (bus)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic strobes(input int n);
    for (int i = 0; i < n; i++) begin
      bus.iXAvail = 1'b1;
      tick();
    end
    bus.iXAvail = 1'b0;
  endtask

  task automatic sync_pulse();
    bus.iFrameSync = 1'b1;
    tick();
    bus.iFrameSync = 1'b0;
  endtask

  task automatic do_reset();
    iRST_N = 1'b0;
    #2;
    iRST_N = 1'b1;
    tick();
  endtask

  task automatic train_pass();
    bus.iTrain = 1'b1;
    tick();
    bus.iTrain = 1'b0;
    sync_pulse();
    tick();
    strobes(16);
    tick();
    tick();
    sync_pulse();
    strobes(16);
    tick();
  endtask

  initial begin
    n_cmp          = 0;
    n_err          = 0;
    iRST_N         = 1'b0;
    bus.iFrameSync = 1'b0;
    bus.iXAvail    = 1'b0;
    bus.iXFull     = 1'b0;
    bus.iTrain     = 1'b0;

    // Reset state
    repeat (2) @(posedge iCLK);
    #1;
    check("rst_state", 32'(bus.oState), 0);
    check("rst_busy", 32'(bus.oBusy), 0);
    check("rst_err", 32'(bus.oErr), 0);
    check("rst_epoch", 32'(bus.oEpoch), 0);
    check("rst_pend", 32'(bus.oTrainPend), 0);
    check("rst_newframe", 32'(bus.oNewFrame), 0);
    iRST_N = 1'b1;
    tick();
    $display("step reset: state=%0d", bus.oState);

    // T2: classify only
    sync_pulse();
    check("t2_clear_state", 32'(bus.oState), 1);
    check("t2_newframe", 32'(bus.oNewFrame), 1);
    check("t2_busy", 32'(bus.oBusy), 1);
    tick();
    check("t2_accum_state", 32'(bus.oState), 2);
    check("t2_computeh", 32'(bus.oComputeH), 1);
    check("t2_newframe_off", 32'(bus.oNewFrame), 0);
    strobes(15);
    check("t2_still_accum", 32'(bus.oState), 2);
    strobes(1);
    check("t2_classify_state", 32'(bus.oState), 3);
    check("t2_classify_1", 32'(bus.oClassify), 1);
    check("t2_computeh_off", 32'(bus.oComputeH), 0);
    tick();
    check("t2_classify_2", 32'(bus.oClassify), 1);
    tick();
    check("t2_idle", 32'(bus.oState), 0);
    check("t2_classify_off", 32'(bus.oClassify), 0);
    check("t2_busy_off", 32'(bus.oBusy), 0);
    check("t2_epoch", 32'(bus.oEpoch), 0);
    check("t2_err", 32'(bus.oErr), 0);
    $display("step T2 classify: state=%0d epoch=%0d err=%0d", bus.oState, bus.oEpoch, bus.oErr);

    // T3: train request during ACCUM, update pass on the next frame
    sync_pulse();
    tick();
    bus.iTrain = 1'b1;
    strobes(1);
    bus.iTrain = 1'b0;
    check("t3_pend_set", 32'(bus.oTrainPend), 1);
    strobes(15);
    check("t3_classify", 32'(bus.oState), 3);
    tick();
    tick();
    check("t3_wait_upd", 32'(bus.oState), 4);
    tick();
    check("t3_wait_hold", 32'(bus.oState), 4);
    sync_pulse();
    check("t3_update", 32'(bus.oState), 5);
    check("t3_uprule", 32'(bus.oUpRule), 1);
    check("t3_no_newframe", 32'(bus.oNewFrame), 0);
    strobes(15);
    check("t3_still_update", 32'(bus.oState), 5);
    strobes(1);
    check("t3_done", 32'(bus.oState), 6);
    check("t3_uprule_off", 32'(bus.oUpRule), 0);
    tick();
    check("t3_idle", 32'(bus.oState), 0);
    check("t3_epoch", 32'(bus.oEpoch), 1);
    check("t3_pend_clr", 32'(bus.oTrainPend), 0);
    $display("step T3 train: epoch=%0d pend=%0d", bus.oEpoch, bus.oTrainPend);

    // T1: asynchronous reset in the middle of UPDATE
    bus.iTrain = 1'b1;
    tick();
    bus.iTrain = 1'b0;
    check("t1_pend_idle", 32'(bus.oTrainPend), 1);
    sync_pulse();
    tick();
    strobes(16);
    tick();
    tick();
    sync_pulse();
    strobes(3);
    check("t1_in_update", 32'(bus.oState), 5);
    #2;
    iRST_N = 1'b0;
    #1;
    check("t1_state", 32'(bus.oState), 0);
    check("t1_uprule", 32'(bus.oUpRule), 0);
    check("t1_busy", 32'(bus.oBusy), 0);
    check("t1_epoch", 32'(bus.oEpoch), 0);
    check("t1_pend", 32'(bus.oTrainPend), 0);
    iRST_N = 1'b1;
    tick();
    $display("step T1 async reset: state=%0d epoch=%0d", bus.oState, bus.oEpoch);

    // T4: short frame ended by iXFull
    sync_pulse();
    tick();
    strobes(10);
    bus.iXFull = 1'b1;
    tick();
    bus.iXFull = 1'b0;
    check("t4_classify", 32'(bus.oState), 3);
    check("t4_err", 32'(bus.oErr), 1);
    tick();
    tick();
    check("t4_idle", 32'(bus.oState), 0);
    check("t4_err_sticky", 32'(bus.oErr), 1);
    $display("step T4 short frame: err=%0d", bus.oErr);

    // T5: truncated frame restarts the pass
    do_reset();
    check("t5_err_cleared", 32'(bus.oErr), 0);
    sync_pulse();
    tick();
    strobes(5);
    sync_pulse();
    check("t5_clear", 32'(bus.oState), 1);
    check("t5_newframe", 32'(bus.oNewFrame), 1);
    check("t5_err", 32'(bus.oErr), 1);
    tick();
    check("t5_accum", 32'(bus.oState), 2);
    strobes(15);
    check("t5_count_restarted", 32'(bus.oState), 2);
    strobes(1);
    check("t5_classify", 32'(bus.oState), 3);
    tick();
    tick();
    $display("step T5 truncation: state=%0d err=%0d", bus.oState, bus.oErr);

    // Exit condition and frame sync in the same cycle: exit wins
    do_reset();
    sync_pulse();
    tick();
    strobes(15);
    bus.iFrameSync = 1'b1;
    strobes(1);
    bus.iFrameSync = 1'b0;
    check("race_classify", 32'(bus.oState), 3);
    check("race_err", 32'(bus.oErr), 0);
    tick();
    tick();
    $display("step exit-vs-sync: err=%0d", bus.oErr);

    // Epoch counter wraps modulo 4
    do_reset();
    for (int p = 1; p <= 4; p++) begin
      train_pass();
      check("epoch_wrap", 32'(bus.oEpoch), 32'(p % 4));
      $display("step update pass %0d: epoch=%0d", p, bus.oEpoch);
    end
    check("epoch_idle", 32'(bus.oState), 0);

`ifdef NN_SEQ_WDOG_EN
    // Watchdog: ACCUM with no strobes gives up after 100 cycles
    do_reset();
    sync_pulse();
    tick();
    repeat (99) tick();
    check("wdog_still_accum", 32'(bus.oState), 2);
    tick();
    check("wdog_idle", 32'(bus.oState), 0);
    check("wdog_err", 32'(bus.oErr), 1);
    $display("step watchdog: state=%0d err=%0d", bus.oState, bus.oErr);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
